// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - loader_state_e : loader FSM states
//   - BYTE_WIDTH     : width of one stream element
//   - bpw()          : bytes per instruction word for a given word width
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } loader_state_e;

  // Number of stream bytes that make up one instruction word.
  function automatic int bpw(input int word_length);
    return word_length / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
// Byte stream into the instruction-memory loader (valid/ready handshake).
//   in_data  : stream byte
//   in_valid : in_data is valid
//   in_ready : loader accepts a byte this cycle
// Modports:
//   master : byte producer (boot interface / testbench)
//   slave  : the loader
// -----------------------------------------------------------------------------
interface instr_mem_loader_if;
  import instr_loader_pkg::*;

  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
// Packs a stream of bytes into one WORD_LENGTH word, first byte most
// significant. Used both for data words and for the checksum word.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous clear of the shift register and byte counter
//   shift_en   : a byte is accepted this cycle
//   byte_in    : the byte being accepted
//   word       : assembled word including the byte accepted this cycle, so the
//                parent can register it on the same edge that completes it
//   full       : this cycle's byte completes the word
// -----------------------------------------------------------------------------
module byte_assembler
  import instr_loader_pkg::*;
#(
  parameter int WORD_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   shift_en,
  input  logic [BYTE_WIDTH-1:0]  byte_in,
  output logic [WORD_LENGTH-1:0] word,
  output logic                   full
);

  localparam int BPW = bpw(WORD_LENGTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BPW - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] ZERO_C   = CW'(0);

  logic [WORD_LENGTH-1:0] shift_r;
  logic [WORD_LENGTH-1:0] shifted_s;
  logic [CW-1:0]          count_r;

  // Next shift-register value and the look-ahead word/full outputs.
  always_comb begin
    shifted_s = (shift_r << BYTE_WIDTH) | WORD_LENGTH'(byte_in);
    if (shift_en) begin
      word = shifted_s;
      full = (count_r == LAST_IDX);
    end else begin
      word = shift_r;
      full = 1'b0;
    end
  end

  // Shift register and byte counter; the counter rolls over once a word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= {WORD_LENGTH{1'b0}};
      count_r <= ZERO_C;
    end else if (clear) begin
      shift_r <= {WORD_LENGTH{1'b0}};
      count_r <= ZERO_C;
    end else if (shift_en) begin
      shift_r <= shifted_s;
      if (count_r == LAST_IDX) begin
        count_r <= ZERO_C;
      end else begin
        count_r <= count_r + ONE_C;
      end
    end else begin
      shift_r <= shift_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Write-side companion to the instruction memory. Accepts a byte stream,
// assembles bytes into instruction words (first byte = MSB) and writes them
// to consecutive word addresses starting at base_addr.
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//   When defined, an XOR of all written words is compared against one extra
//   checksum word streamed after the data; err flags a mismatch and holds
//   until the next start or reset. When undefined, err is tied to 0.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a load (sampled only while idle)
//   base_addr    : first word address, captured on start
//   word_count   : words to write, captured on start
//   stream       : byte stream slave (in_data / in_valid / in_ready)
//   mem_we       : one-cycle write strobe per word
//   MAR, MDR     : write address / data, zero whenever mem_we is low
//   busy         : from the cycle after start through the done pulse
//   done         : one-cycle completion pulse
//   err          : checksum mismatch flag
// -----------------------------------------------------------------------------
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int WORD_LENGTH   = 16,
  parameter int ADDRESS_SPACE = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_SPACE-1:0] base_addr,
  input  logic [ADDRESS_SPACE-1:0] word_count,
  instr_mem_loader_if.slave        stream,
  output logic                     mem_we,
  output logic [ADDRESS_SPACE-1:0] MAR,
  output logic [WORD_LENGTH-1:0]   MDR,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [ADDRESS_SPACE-1:0] ZERO_A = {ADDRESS_SPACE{1'b0}};
  localparam logic [ADDRESS_SPACE-1:0] ONE_A  = {{(ADDRESS_SPACE-1){1'b0}}, 1'b1};
  localparam logic [WORD_LENGTH-1:0]   ZERO_W = {WORD_LENGTH{1'b0}};

  loader_state_e              state_r;
  logic [ADDRESS_SPACE-1:0]   addr_r;
  logic [ADDRESS_SPACE-1:0]   remain_r;
  logic                       in_ready_r;
  logic                       mem_we_r;
  logic [ADDRESS_SPACE-1:0]   mar_r;
  logic [WORD_LENGTH-1:0]     mdr_r;
  logic                       busy_r;
  logic                       done_r;

  logic                       accept_s;
  logic                       clear_s;
  logic [WORD_LENGTH-1:0]     asm_word_s;
  logic                       asm_full_s;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [WORD_LENGTH-1:0]     acc_r;
  logic                       err_r;
`endif

  // Handshake completion and assembler clear; the assembler is held empty while idle.
  always_comb begin
    accept_s = stream.in_valid && in_ready_r;
    clear_s  = (state_r == IDLE);
  end

  byte_assembler #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .shift_en (accept_s),
    .byte_in  (stream.in_data),
    .word     (asm_word_s),
    .full     (asm_full_s)
  );

  // Loader FSM. Every output is registered and set on the edge that enters
  // the state it belongs to, so mem_we lands one cycle after the last byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      addr_r     <= ZERO_A;
      remain_r   <= ZERO_A;
      in_ready_r <= 1'b0;
      mem_we_r   <= 1'b0;
      mar_r      <= ZERO_A;
      mdr_r      <= ZERO_W;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      acc_r      <= ZERO_W;
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r   <= base_addr;
            remain_r <= word_count;
            busy_r   <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            acc_r    <= ZERO_W;
            err_r    <= 1'b0;
`endif
            if (word_count == ZERO_A) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= COLLECT;
              in_ready_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        COLLECT: begin
          if (accept_s && asm_full_s) begin
            state_r    <= WRITE;
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b1;
            mar_r      <= addr_r;
            mdr_r      <= asm_word_s;
`ifdef INSTR_LOADER_CHECKSUM_EN
            acc_r      <= acc_r ^ asm_word_s;
`endif
          end else begin
            state_r <= COLLECT;
          end
        end

        WRITE: begin
          mem_we_r <= 1'b0;
          mar_r    <= ZERO_A;
          mdr_r    <= ZERO_W;
          // Natural truncation gives the wrap from the top address to 0.
          addr_r   <= addr_r + ONE_A;
          remain_r <= remain_r - ONE_A;
          if (remain_r == ONE_A) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state_r    <= CHECK;
            in_ready_r <= 1'b1;
`else
            state_r    <= DONE;
            done_r     <= 1'b1;
`endif
          end else begin
            state_r    <= COLLECT;
            in_ready_r <= 1'b1;
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        CHECK: begin
          // The checksum word goes through the same assembler but is never written.
          if (accept_s && asm_full_s) begin
            state_r    <= DONE;
            in_ready_r <= 1'b0;
            done_r     <= 1'b1;
            err_r      <= (asm_word_s != acc_r);
          end else begin
            state_r <= CHECK;
          end
        end
`endif

        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          mem_we_r   <= 1'b0;
          mar_r      <= ZERO_A;
          mdr_r      <= ZERO_W;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign stream.in_ready = in_ready_r;
  assign mem_we          = mem_we_r;
  assign MAR             = mar_r;
  assign MDR             = mdr_r;
  assign busy            = busy_r;
  assign done            = done_r;

`ifdef INSTR_LOADER_CHECKSUM_EN
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Scoreboard bench: each load pushes its expected writes and completion into
// queues; a negedge monitor pops and compares whenever the DUT writes or
// signals done. Directed cases followed by randomized loads.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int WL = 16;
  localparam int AS = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AS-1:0] base_addr;
  logic [AS-1:0] word_count;
  logic          mem_we;
  logic [AS-1:0] MAR;
  logic [WL-1:0] MDR;
  logic          busy;
  logic          done;
  logic          err;

  instr_mem_loader_if stream ();

  instr_mem_loader #(
    .WORD_LENGTH   (WL),
    .ADDRESS_SPACE (AS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .stream     (stream),
    .mem_we     (mem_we),
    .MAR        (MAR),
    .MDR        (MDR),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AS-1:0] addr;
    logic [WL-1:0] data;
  } wr_t;

  // kind: 0 = done right after start, 1 = right after a write, 2 = right after a byte
  typedef struct packed {
    logic       err;
    logic [1:0] kind;
  } dn_t;

  wr_t           exp_wr_q[$];
  dn_t           exp_dn_q[$];
  logic [WL-1:0] words_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            csum_force = 1'b0;
  logic [WL-1:0] csum_value = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_accept = 1'b0;
  logic prev_we     = 1'b0;
  logic prev_start  = 1'b0;
  wr_t  mw;
  dn_t  md;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("we_after_byte", 32'(prev_accept), 32'd1);
      check("ready_low_in_write", 32'(stream.in_ready), 32'd0);
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        mw = exp_wr_q.pop_front();
        check("MAR", 32'(MAR), 32'(mw.addr));
        check("MDR", 32'(MDR), 32'(mw.data));
      end
    end else begin
      check("MAR_zero", 32'(MAR), 32'd0);
      check("MDR_zero", 32'(MDR), 32'd0);
    end
    if (mem_we === 1'b1 || done === 1'b1 || stream.in_ready === 1'b1)
      check("busy_active", 32'(busy), 32'd1);
    if (done === 1'b1) begin
      if (exp_dn_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        md = exp_dn_q.pop_front();
        check("err_at_done", 32'(err), 32'(md.err));
        case (md.kind)
          2'd0:    check("done_after_start", 32'(prev_start), 32'd1);
          2'd1:    check("done_after_write", 32'(prev_we), 32'd1);
          default: check("done_after_csum", 32'(prev_accept), 32'd1);
        endcase
      end
    end
    prev_accept <= stream.in_valid && stream.in_ready;
    prev_we     <= mem_we;
    prev_start  <= start;
  end

  // ---------------- driver ----------------
  // gap: 0 continuous valid, 1 valid on alternate cycles, 2 random valid
  task automatic do_load(input logic [AS-1:0] base, input logic [AS-1:0] cnt,
                         input int gap, input bit poke_start);
    logic [7:0]    bytes[$];
    logic [WL-1:0] acc;
    logic [WL-1:0] w;
    logic [AS-1:0] a;
    logic [WL-1:0] cs;
    logic          e;
    logic          v;
    logic          hs;
    int            idx;
    int            budget;
    acc = 16'h0000;
    e   = 1'b0;
    cs  = 16'h0000;
    // reference model: consecutive addresses modulo 2^AS, MSB byte first
    for (int i = 0; i < int'(cnt); i++) begin
      w = words_q[i];
      a = AS'((longint'(base) + longint'(i)) % (longint'(1) << AS));
      exp_wr_q.push_back('{addr: a, data: w});
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
      acc = acc ^ w;
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (cnt != 0) begin
      cs = csum_force ? csum_value : acc;
      bytes.push_back(cs[15:8]);
      bytes.push_back(cs[7:0]);
      e = (cs != acc);
      exp_dn_q.push_back('{err: e, kind: 2'd2});
    end else begin
      exp_dn_q.push_back('{err: 1'b0, kind: 2'd0});
    end
`else
    exp_dn_q.push_back('{err: e, kind: (cnt == 0) ? 2'd0 : 2'd1});
`endif

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = cnt;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AS'($urandom); word_count = AS'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_clear_on_start", 32'(err), 32'd0);
    if (cnt == 0) begin
      check("zero_done_next", 32'(done), 32'd1);
      check("zero_ready_low", 32'(stream.in_ready), 32'd0);
    end

    idx = 0;
    budget = 0;
    while (idx < bytes.size() && budget < 2000) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      stream.in_valid = v;
      stream.in_data  = v ? bytes[idx] : 8'($urandom);
      if (poke_start) begin
        start     = ($urandom_range(0, 5) == 0);
        base_addr = AS'($urandom);
        word_count = AS'($urandom);
      end
      hs = v && stream.in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      budget++;
    end
    stream.in_valid = 1'b0;
    start = 1'b0;
    if (idx < bytes.size()) check("byte_budget", 32'(idx), 32'(bytes.size()));

    budget = 0;
    while (done !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("busy_low_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AS-1:0] b;
    logic [AS-1:0] c;
    reset = 1'b1;
    start = 1'b0;
    base_addr = 21'h0;
    word_count = 21'h0;
    stream.in_valid = 1'b0;
    stream.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(stream.in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_MAR", 32'(MAR), 32'd0);
    check("rst_MDR", 32'(MDR), 32'd0);
    reset = 1'b0;

    // normal load
    words_q = '{16'h1234, 16'hABCD};
    do_load(21'h10, 21'd2, 0, 1'b0);
    // zero count
    words_q.delete();
    do_load(21'h55, 21'd0, 0, 1'b0);
    // backpressure
    words_q = '{16'h1234, 16'hABCD};
    do_load(21'h10, 21'd2, 1, 1'b0);
    // wrap-around
    words_q = '{16'h0F0F, 16'hF00D};
    do_load(21'h1FFFFF, 21'd2, 0, 1'b0);

    // reset after one byte: no write, everything zero, then a clean load
    @(posedge clk); #1;
    start = 1'b1; base_addr = 21'h40; word_count = 21'd2;
    @(posedge clk); #1;
    start = 1'b0;
    stream.in_valid = 1'b1; stream.in_data = 8'h55;
    @(posedge clk); #1;
    stream.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(stream.in_ready), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_MAR", 32'(MAR), 32'd0);
    check("mid_rst_MDR", 32'(MDR), 32'd0);
    words_q = '{16'hBEEF};
    do_load(21'h20, 21'd1, 0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    words_q = '{16'h1234, 16'hABCD};
    csum_force = 1'b1; csum_value = 16'hB9F9;
    do_load(21'h10, 21'd2, 0, 1'b0);
    csum_value = 16'h0000;
    do_load(21'h10, 21'd2, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("err_held", 32'(err), 32'd1);
    csum_force = 1'b0;
`endif

    // randomized loads
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0:       b = AS'(21'h1FFFFC + AS'($urandom_range(0, 3)));
        default: b = AS'($urandom);
      endcase
      c = ($urandom_range(0, 9) == 0) ? 21'd0 : AS'($urandom_range(1, 5));
      words_q.delete();
      for (int i = 0; i < int'(c); i++) words_q.push_back(WL'($urandom));
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_force = ($urandom_range(0, 2) == 0);
      csum_value = WL'($urandom);
`endif
      do_load(b, c, $urandom_range(0, 2), 1'b1);
    end

`ifndef INSTR_LOADER_CHECKSUM_EN
    check("err_tied_low", 32'(err), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
    check("dones_drained", 32'(exp_dn_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
